// File: rtl/ecc_ram_pkg.sv
// rtl/ecc_ram_pkg.sv - shared types and constants for the ECC zeroizable TDP RAM
// Contents: zeroize FSM state enum, byte width, depth helper.
package ecc_ram_pkg;

  typedef enum logic [0:0] {
    ZS_IDLE  = 1'b0,
    ZS_CLEAR = 1'b1
  } zs_state_e;

  localparam int BYTE_W = 8;

  function automatic int ram_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/ecc_ram_zeroize_ctrl.sv
// rtl/ecc_ram_zeroize_ctrl.sv - zeroize sweep FSM and port override for the ECC TDP RAM
// Ports:
//   clk, reset                     clock, async active-high reset
//   zeroize                        sweep request (also restarts a running sweep)
//   ena/wea/addra/dina             user port A request
//   enb/web/addrb/dinb             user port B request
//   mem_we*/mem_addr*/mem_din*     effective array write controls per port
//   rd_a, rd_b                     effective read strobes per port
//   blank                          user access blocked, read outputs forced to 0
//   zeroize_busy, zeroize_done     sweep status / completion pulse
//   collision                      same-address dual write pulse (one cycle late)
module ecc_ram_zeroize_ctrl
  import ecc_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / BYTE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  zeroize,
  input  logic                  ena,
  input  logic [BE_WIDTH-1:0]   wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic                  enb,
  input  logic [BE_WIDTH-1:0]   web,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] dinb,
  output logic [BE_WIDTH-1:0]   mem_wea,
  output logic [ADDR_WIDTH-1:0] mem_addra,
  output logic [DATA_WIDTH-1:0] mem_dina,
  output logic                  rd_a,
  output logic [BE_WIDTH-1:0]   mem_web,
  output logic [ADDR_WIDTH-1:0] mem_addrb,
  output logic [DATA_WIDTH-1:0] mem_dinb,
  output logic                  rd_b,
  output logic                  blank,
  output logic                  zeroize_busy,
  output logic                  zeroize_done,
  output logic                  collision
);

  // Port A clears the even word of each pair, so the final pair starts at depth-2.
  localparam logic [ADDR_WIDTH-1:0] LAST_PAIR = ~ADDR_WIDTH'(1);

  zs_state_e             state, state_n;
  logic [ADDR_WIDTH-1:0] cnt, cnt_n;
  logic                  done_n;
  logic                  coll_n;
  logic                  clearing;
  logic                  user_wa;
  logic                  user_wb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ZS_IDLE;
      cnt          <= '0;
      zeroize_done <= 1'b0;
      collision    <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      zeroize_done <= done_n;
      collision    <= coll_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    done_n  = 1'b0;
    case (state)
      ZS_IDLE: begin
        if (zeroize) begin
          state_n = ZS_CLEAR;
          cnt_n   = '0;
        end
      end
      ZS_CLEAR: begin
        // A repeated request restarts from word 0 and defers the done pulse.
        if (zeroize) begin
          cnt_n = '0;
        end else if (cnt == LAST_PAIR) begin
          state_n = ZS_IDLE;
          cnt_n   = '0;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + ADDR_WIDTH'(2);
        end
      end
      default: state_n = ZS_IDLE;
    endcase
  end

  assign clearing     = (state == ZS_CLEAR);
  // The done cycle is also blanked so no user access lands directly after the sweep.
  assign blank        = clearing | zeroize_done;
  assign zeroize_busy = clearing;
  assign user_wa      = ena & (|wea);
  assign user_wb      = enb & (|web);

  always_comb begin
    mem_wea   = '0;
    mem_addra = addra;
    mem_dina  = dina;
    rd_a      = 1'b0;
    mem_web   = '0;
    mem_addrb = addrb;
    mem_dinb  = dinb;
    rd_b      = 1'b0;
    coll_n    = 1'b0;
    if (clearing) begin
      mem_wea   = '1;
      mem_addra = cnt;
      mem_dina  = '0;
      mem_web   = '1;
      mem_addrb = cnt | ADDR_WIDTH'(1);
      mem_dinb  = '0;
    end else if (!zeroize_done) begin
      // Port A wins a same-address write; port B's write is dropped whole.
      coll_n  = user_wa & user_wb & (addra == addrb);
      mem_wea = ena ? wea : '0;
      mem_web = (enb & ~coll_n) ? web : '0;
      rd_a    = ena & ~(|wea);
      rd_b    = enb & ~(|web);
    end
  end

endmodule

// File: rtl/ecc_ram_tdp_zeroize_file.sv
// rtl/ecc_ram_tdp_zeroize_file.sv - true-dual-port byte-write RAM with hardware zeroize sweep
// Ports:
//   clk, reset                         clock, async active-high reset (array not cleared)
//   zeroize                            request to clear every word
//   ena/wea/addra/dina/douta/rvalida   port A (byte writes, read data + valid strobe)
//   enb/web/addrb/dinb/doutb/rvalidb   port B
//   zeroize_busy, zeroize_done         sweep in progress / completion pulse
//   collision                          both ports wrote the same word (A kept)
// OUT_REG=0 gives 1-cycle read latency, OUT_REG=1 adds an output register (2 cycles).
module ecc_ram_tdp_zeroize_file
  import ecc_ram_pkg::*;
#(
  parameter  int ADDR_WIDTH = 10,
  parameter  int DATA_WIDTH = 32,
  parameter  int OUT_REG    = 0,
  localparam int BE_WIDTH   = DATA_WIDTH / BYTE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  zeroize,
  input  logic                  ena,
  input  logic [BE_WIDTH-1:0]   wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  output logic [DATA_WIDTH-1:0] douta,
  output logic                  rvalida,
  input  logic                  enb,
  input  logic [BE_WIDTH-1:0]   web,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] dinb,
  output logic [DATA_WIDTH-1:0] doutb,
  output logic                  rvalidb,
  output logic                  zeroize_busy,
  output logic                  zeroize_done,
  output logic                  collision
);

  localparam int DEPTH = ram_depth(ADDR_WIDTH);

  logic [BE_WIDTH-1:0]   mem_wea, mem_web;
  logic [ADDR_WIDTH-1:0] mem_addra, mem_addrb;
  logic [DATA_WIDTH-1:0] mem_dina, mem_dinb;
  logic                  rd_a, rd_b;
  logic                  blank;

  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DATA_WIDTH-1:0] q1a, q1b, q2a, q2b;
  logic                  v1a, v1b, v2a, v2b;

  ecc_ram_zeroize_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BE_WIDTH   (BE_WIDTH)
  ) u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .zeroize      (zeroize),
    .ena          (ena),
    .wea          (wea),
    .addra        (addra),
    .dina         (dina),
    .enb          (enb),
    .web          (web),
    .addrb        (addrb),
    .dinb         (dinb),
    .mem_wea      (mem_wea),
    .mem_addra    (mem_addra),
    .mem_dina     (mem_dina),
    .rd_a         (rd_a),
    .mem_web      (mem_web),
    .mem_addrb    (mem_addrb),
    .mem_dinb     (mem_dinb),
    .rd_b         (rd_b),
    .blank        (blank),
    .zeroize_busy (zeroize_busy),
    .zeroize_done (zeroize_done),
    .collision    (collision)
  );

  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (mem_wea[i]) mem[mem_addra][i*BYTE_W +: BYTE_W] <= mem_dina[i*BYTE_W +: BYTE_W];
      if (mem_web[i]) mem[mem_addrb][i*BYTE_W +: BYTE_W] <= mem_dinb[i*BYTE_W +: BYTE_W];
    end
  end

  // Read registers sample the array before this edge's writes land (read-first).
  // They are wiped while blanked so no pre-zeroize data reappears afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q1a <= '0; q1b <= '0; q2a <= '0; q2b <= '0;
      v1a <= 1'b0; v1b <= 1'b0; v2a <= 1'b0; v2b <= 1'b0;
    end else if (blank) begin
      q1a <= '0; q1b <= '0; q2a <= '0; q2b <= '0;
      v1a <= 1'b0; v1b <= 1'b0; v2a <= 1'b0; v2b <= 1'b0;
    end else begin
      v1a <= rd_a;
      v1b <= rd_b;
      if (rd_a) q1a <= mem[mem_addra];
      if (rd_b) q1b <= mem[mem_addrb];
      v2a <= v1a;
      v2b <= v1b;
      if (v1a) q2a <= q1a;
      if (v1b) q2b <= q1b;
    end
  end

  always_comb begin
    douta   = '0;
    doutb   = '0;
    rvalida = 1'b0;
    rvalidb = 1'b0;
    if (!blank) begin
      if (OUT_REG != 0) begin
        douta   = q2a;
        doutb   = q2b;
        rvalida = v2a;
        rvalidb = v2b;
      end else begin
        douta   = q1a;
        doutb   = q1b;
        rvalida = v1a;
        rvalidb = v1b;
      end
    end
  end

endmodule

// File: tb/tb_ecc_ram_tdp_zeroize_file.sv
// tb/tb_ecc_ram_tdp_zeroize_file.sv - self-checking bench for ecc_ram_tdp_zeroize_file (OUT_REG 0 and 1)
module tb_ecc_ram_tdp_zeroize_file;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int BW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          zeroize = 1'b0;
  logic          ena = 1'b0, enb = 1'b0;
  logic [BW-1:0] wea = '0, web = '0;
  logic [AW-1:0] addra = '0, addrb = '0;
  logic [DW-1:0] dina = '0, dinb = '0;

  logic [DW-1:0] douta0, doutb0, douta1, doutb1;
  logic          rva0, rvb0, rva1, rvb1;
  logic          busy0, busy1, done0, done1, coll0, coll1;

  always #5 clk = ~clk;

  ecc_ram_tdp_zeroize_file #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(0)) dut0 (
    .clk(clk), .reset(reset), .zeroize(zeroize),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta0), .rvalida(rva0),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb0), .rvalidb(rvb0),
    .zeroize_busy(busy0), .zeroize_done(done0), .collision(coll0)
  );

  ecc_ram_tdp_zeroize_file #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1)) dut1 (
    .clk(clk), .reset(reset), .zeroize(zeroize),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta1), .rvalida(rva1),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb1), .rvalidb(rvb1),
    .zeroize_busy(busy1), .zeroize_done(done1), .collision(coll1)
  );

  // Behavioural model: array contents, sweep cycles remaining, expected outputs.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_clear, m_post;
  int            m_left;
  logic [DW-1:0] e_da0, e_db0, e_da1, e_db1;
  bit            e_va0, e_vb0, e_va1, e_vb1, e_busy, e_done, e_coll;
  logic [DW-1:0] h_a0, h_b0, h_a1, h_b1, p_da, p_db;
  bit            p_va, p_vb;

  int n_cmp = 0, n_bad = 0;
  int busy_cyc = 0, done_cnt = 0, coll_cnt = 0;

  task automatic chk32(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_clear = 0; m_post = 0; m_left = 0;
    e_da0 = '0; e_db0 = '0; e_da1 = '0; e_db1 = '0;
    e_va0 = 0; e_vb0 = 0; e_va1 = 0; e_vb1 = 0;
    e_busy = 0; e_done = 0; e_coll = 0;
    h_a0 = '0; h_b0 = '0; h_a1 = '0; h_b1 = '0;
    p_va = 0; p_vb = 0; p_da = '0; p_db = '0;
  endtask

  // Applies one rising edge's worth of behaviour using the inputs of the ending cycle.
  task automatic model_edge();
    bit blank_now, ra, rb, wa, wb, coll, nb, done_n;
    logic [DW-1:0] rda, rdb;
    if (reset) begin
      model_reset();
      return;
    end
    blank_now = m_clear || m_post;
    ra   = !blank_now && ena && (wea == '0);
    rb   = !blank_now && enb && (web == '0);
    wa   = !blank_now && ena && (wea != '0);
    wb   = !blank_now && enb && (web != '0);
    rda  = m_mem[addra];
    rdb  = m_mem[addrb];
    coll = wa && wb && (addra == addrb);
    for (int i = 0; i < BW; i++) begin
      if (wa && wea[i]) m_mem[addra][i*8 +: 8] = dina[i*8 +: 8];
      if (wb && !coll && web[i]) m_mem[addrb][i*8 +: 8] = dinb[i*8 +: 8];
    end
    done_n = 0;
    if (m_clear) begin
      if (zeroize) m_left = DEPTH / 2;
      else begin
        m_left--;
        if (m_left == 0) begin
          m_clear = 0;
          done_n  = 1;
          for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end
      end
    end else if (zeroize) begin
      m_clear = 1;
      m_left  = DEPTH / 2;
    end
    m_post = done_n;
    e_done = done_n;
    e_coll = coll;
    e_busy = m_clear;
    nb = m_clear || m_post;
    if (nb) begin
      e_da0 = '0; e_db0 = '0; e_da1 = '0; e_db1 = '0;
      e_va0 = 0; e_vb0 = 0; e_va1 = 0; e_vb1 = 0;
      h_a0 = '0; h_b0 = '0; h_a1 = '0; h_b1 = '0;
      p_va = 0; p_vb = 0;
    end else begin
      e_va0 = ra; if (ra) h_a0 = rda; e_da0 = h_a0;
      e_vb0 = rb; if (rb) h_b0 = rdb; e_db0 = h_b0;
      e_va1 = p_va; if (p_va) h_a1 = p_da; e_da1 = h_a1;
      e_vb1 = p_vb; if (p_vb) h_b1 = p_db; e_db1 = h_b1;
      p_va = ra; p_da = rda;
      p_vb = rb; p_db = rdb;
    end
  endtask

  task automatic check_model();
    chk32("douta0", douta0, e_da0);
    chk32("doutb0", doutb0, e_db0);
    chk32("douta1", douta1, e_da1);
    chk32("doutb1", doutb1, e_db1);
    chk1("rvalida0", rva0, e_va0);
    chk1("rvalidb0", rvb0, e_vb0);
    chk1("rvalida1", rva1, e_va1);
    chk1("rvalidb1", rvb1, e_vb1);
    chk1("busy0", busy0, e_busy);
    chk1("busy1", busy1, e_busy);
    chk1("done0", done0, e_done);
    chk1("done1", done1, e_done);
    chk1("coll0", coll0, e_coll);
    chk1("coll1", coll1, e_coll);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
    if (busy0) busy_cyc++;
    if (done0) done_cnt++;
    if (coll0) coll_cnt++;
  endtask

  task automatic drive(input logic a_en, input logic [BW-1:0] a_we, input logic [AW-1:0] a_ad,
                       input logic [DW-1:0] a_d, input logic b_en, input logic [BW-1:0] b_we,
                       input logic [AW-1:0] b_ad, input logic [DW-1:0] b_d, input logic z);
    ena = a_en; wea = a_we; addra = a_ad; dina = a_d;
    enb = b_en; web = b_we; addrb = b_ad; dinb = b_d;
    zeroize = z;
  endtask

  task automatic idle();
    ena = 1'b0; wea = '0; addra = '0; dina = '0;
    enb = 1'b0; web = '0; addrb = '0; dinb = '0;
    zeroize = 1'b0;
  endtask

  task automatic read_pair(input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                           input logic [DW-1:0] xa, input logic [DW-1:0] xb, input string tag);
    drive(1'b1, '0, aa, '0, 1'b1, '0, ab, '0, 1'b0);
    step();
    idle();
    chk32({tag, "_a_lat1"}, douta0, xa);
    chk32({tag, "_b_lat1"}, doutb0, xb);
    chk1({tag, "_rva_lat1"}, rva0, 1'b1);
    chk1({tag, "_rva_r1_early"}, rva1, 1'b0);
    step();
    chk32({tag, "_a_lat2"}, douta1, xa);
    chk32({tag, "_b_lat2"}, doutb1, xb);
    chk1({tag, "_rvb_lat2"}, rvb1, 1'b1);
    chk1({tag, "_rva_r0_once"}, rva0, 1'b0);
  endtask

  task automatic wait_done(input string tag);
    int  start;
    bit  seen;
    start = done_cnt;
    seen  = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      step();
      if (done_cnt != start) seen = 1;
    end
    chk1({tag, "_done_seen"}, seen, 1'b1);
  endtask

  function automatic logic [DW-1:0] pat(input int a);
    return DW'(a) ^ 32'hC0DE_0000;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, d0, c0;
    model_reset();
    idle();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk32("rst_douta0", douta0, 32'h0);
    chk32("rst_doutb1", doutb1, 32'h0);
    chk1("rst_rvalida0", rva0, 1'b0);
    chk1("rst_busy", busy0, 1'b0);
    chk1("rst_done", done0, 1'b0);
    chk1("rst_coll", coll0, 1'b0);

    // Initial sweep makes the whole array known.
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b1);
    step();
    idle();
    wait_done("init_sweep");
    step();

    // Full write then cross-port read.
    drive(1'b1, 4'hF, 10'd5, 32'hDEAD_BEEF, 1'b0, '0, '0, '0, 1'b0);
    step();
    read_pair(10'd5, 10'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "wr_full");
    step();
    chk32("hold_doutb0", doutb0, 32'hDEAD_BEEF);

    // Byte-enable partial write.
    drive(1'b1, 4'h5, 10'd5, 32'h1122_3344, 1'b0, '0, '0, '0, 1'b0);
    step();
    read_pair(10'd5, 10'd5, 32'hDE22_BE44, 32'hDE22_BE44, "wr_bytes");

    // Same-address collision: A kept, B dropped, single pulse.
    c0 = coll_cnt;
    drive(1'b1, 4'hF, 10'd9, 32'hAAAA_AAAA, 1'b1, 4'hF, 10'd9, 32'h5555_5555, 1'b0);
    step();
    idle();
    step();
    chk_int("coll_pulses", coll_cnt - c0, 1);
    read_pair(10'd9, 10'd9, 32'hAAAA_AAAA, 32'hAAAA_AAAA, "coll_rd");

    // Read-first across ports.
    drive(1'b1, 4'hF, 10'd20, 32'h1234_5678, 1'b0, '0, '0, '0, 1'b0);
    step();
    drive(1'b1, 4'hF, 10'd20, 32'h9ABC_DEF0, 1'b1, '0, 10'd20, '0, 1'b0);
    step();
    idle();
    chk32("rdfirst_b0", doutb0, 32'h1234_5678);
    step();
    chk32("rdfirst_b1", doutb1, 32'h1234_5678);
    read_pair(10'd20, 10'd20, 32'h9ABC_DEF0, 32'h9ABC_DEF0, "rdfirst_new");

    // Randomised traffic on a small address window with occasional zeroize.
    for (int i = 0; i < 3000; i++) begin
      drive(1'b1 & ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
            AW'($urandom_range(0, 15)), $urandom,
            1'b1 & ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
            AW'($urandom_range(0, 15)), $urandom,
            1'b1 & ($urandom_range(0, 999) == 0));
      step();
    end
    idle();
    for (int i = 0; i < 700 && (m_clear || m_post); i++) step();
    step();

    // Fill with address pattern, then zeroize while user writes are attempted.
    for (int i = 0; i < DEPTH / 2; i++) begin
      drive(1'b1, 4'hF, AW'(2 * i), pat(2 * i), 1'b1, 4'hF, AW'(2 * i + 1), pat(2 * i + 1), 1'b0);
      step();
    end
    idle();
    read_pair(10'd3, 10'd1022, pat(3), pat(1022), "fill");
    b0 = busy_cyc;
    d0 = done_cnt;
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b1);
    step();
    for (int i = 0; i < DEPTH / 2; i++) begin
      drive(1'b1, 4'hF, AW'($urandom_range(0, DEPTH - 1)), $urandom,
            1'b1, 4'hF, AW'($urandom_range(0, DEPTH - 1)), $urandom, 1'b0);
      step();
    end
    idle();
    step();
    chk_int("zero_busy_cycles", busy_cyc - b0, 512);
    chk_int("zero_done_pulses", done_cnt - d0, 1);
    read_pair(10'd0, 10'd511, 32'h0, 32'h0, "zero_rd0");
    read_pair(10'd1023, 10'd1023, 32'h0, 32'h0, "zero_rd1023");

    // Restart the sweep during its 100th cycle.
    b0 = busy_cyc;
    d0 = done_cnt;
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b1);
    step();
    idle();
    repeat (99) step();
    zeroize = 1'b1;
    step();
    idle();
    wait_done("restart");
    repeat (3) step();
    chk_int("restart_busy_cycles", busy_cyc - b0, 612);
    chk_int("restart_done_pulses", done_cnt - d0, 1);

    // Reset in the middle of a sweep, then a full re-zeroize.
    drive(1'b1, 4'hF, 10'd77, 32'hFEED_FACE, 1'b0, '0, '0, '0, 1'b0);
    step();
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b1);
    step();
    idle();
    repeat (50) step();
    d0 = done_cnt;
    reset = 1'b1;
    model_reset();
    #1;
    chk1("midrst_busy0", busy0, 1'b0);
    chk1("midrst_busy1", busy1, 1'b0);
    chk1("midrst_done0", done0, 1'b0);
    repeat (2) step();
    reset = 1'b0;
    repeat (5) step();
    chk_int("midrst_no_done", done_cnt - d0, 0);
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b1);
    step();
    idle();
    wait_done("rezero");
    step();
    for (int i = 0; i < DEPTH / 2; i++) begin
      drive(1'b1, '0, AW'(2 * i), '0, 1'b1, '0, AW'(2 * i + 1), '0, 1'b0);
      step();
    end
    idle();
    repeat (3) step();
    read_pair(10'd77, 10'd1001, 32'h0, 32'h0, "rezero_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
